// File: rtl/axi4_ifetch_line_master.sv
// AXI4 read-only line-fill master for instruction fetch: one INCR (or WRAP) burst per request, with flush support.
// Optional critical-word-first fetch is enabled by defining AXI4_IFETCH_CRITICAL_WORD_EN.
module axi4_ifetch_line_master #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 4,
   parameter int AXI_ID    = 0,
   parameter int BURST_LEN = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic                        cancel,
   output logic                        resp_valid,
   output logic [DATA_W*BURST_LEN-1:0] resp_data,
   output logic                        resp_err,
   output logic                        crit_valid,
   output logic [DATA_W-1:0]           crit_data,
   output logic [ID_W-1:0]             arid,
   output logic [ADDR_W-1:0]           araddr,
   output logic [7:0]                  arlen,
   output logic [2:0]                  arsize,
   output logic [1:0]                  arburst,
   output logic                        arlock,
   output logic [3:0]                  arcache,
   output logic [2:0]                  arprot,
   output logic [3:0]                  arqos,
   output logic [3:0]                  arregion,
   output logic                        arvalid,
   input  logic                        arready,
   input  logic [ID_W-1:0]             rid,
   input  logic [DATA_W-1:0]           rdata,
   input  logic [1:0]                  rresp,
   input  logic                        rlast,
   input  logic                        rvalid,
   output logic                        rready
);

   localparam int BEAT_BYTES = DATA_W / 8;
   localparam int LINE_BYTES = BEAT_BYTES * BURST_LEN;
   localparam int IDX_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BURST_LEN - 1);
   localparam logic [IDX_W-1:0]  IDX_MASK  = IDX_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
   localparam logic [ADDR_W-1:0] BEAT_MASK = ~ADDR_W'(BEAT_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_AR    = 2'd1,
      ST_R     = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic              cancel_flag;
   logic [IDX_W-1:0]  beat_cnt;
   logic [IDX_W-1:0]  wr_idx;
   logic [ADDR_W-1:0] araddr_q;
   logic [DATA_W-1:0] line_buf [BURST_LEN];
   logic              beat_fire;
   logic              final_beat;
   logic              unused_axi;

   // Single outstanding burst, so rid and the low RRESP bit carry no information.
   assign unused_axi = ^{rid, rresp[0]};

   assign arid     = ID_W'(AXI_ID);
   assign arlen    = 8'(BURST_LEN - 1);
   assign arsize   = 3'($clog2(BEAT_BYTES));
   assign arlock   = 1'b0;
   assign arcache  = 4'd0;
   assign arprot   = 3'd0;
   assign arqos    = 4'd0;
   assign arregion = 4'd0;
   assign araddr   = araddr_q;

   assign beat_fire  = rvalid && rready;
   assign final_beat = beat_fire && (rlast || (beat_cnt == LAST_IDX));

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = ST_AR;
         end
         ST_AR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = (cancel_flag || cancel) ? ST_DRAIN : ST_R;
         end
         ST_R: begin
            rready = 1'b1;
            // A cancel on the final beat still ends the burst; resp_valid is suppressed below.
            if (final_beat)  state_nxt = ST_IDLE;
            else if (cancel) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            rready = 1'b1;
            if (final_beat) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Control registers: beat counter, cancel flag, response strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cancel_flag <= 1'b0;
         beat_cnt    <= '0;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  cancel_flag <= 1'b0;
                  beat_cnt    <= '0;
                  resp_err    <= 1'b0;
               end
            end
            ST_AR: begin
               if (cancel) cancel_flag <= 1'b1;
            end
            ST_R: begin
               if (beat_fire) begin
                  beat_cnt <= beat_cnt + IDX_W'(1);
                  resp_err <= resp_err | rresp[1];
               end
               if (final_beat && !cancel) resp_valid <= 1'b1;
            end
            ST_DRAIN: begin
               if (beat_fire) beat_cnt <= beat_cnt + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef AXI4_IFETCH_CRITICAL_WORD_EN
   logic [IDX_W-1:0]  start_idx;
   logic [DATA_W-1:0] crit_data_q;
   logic              crit_valid_q;

   assign arburst    = 2'b10;
   assign wr_idx     = (start_idx + beat_cnt) & IDX_MASK;
   assign crit_valid = crit_valid_q;
   assign crit_data  = crit_data_q;

   always_ff @(posedge clk) begin
      if (rst) crit_valid_q <= 1'b0;
      else     crit_valid_q <= (state == ST_R) && beat_fire && (beat_cnt == '0) && !cancel;
   end

   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && req_valid) begin
         araddr_q  <= req_addr & BEAT_MASK;
         start_idx <= IDX_W'(req_addr >> $clog2(BEAT_BYTES)) & IDX_MASK;
      end
      if ((state == ST_R) && beat_fire) begin
         line_buf[wr_idx] <= rdata;
         if (beat_cnt == '0) crit_data_q <= rdata;
      end
   end
`else
   logic [ADDR_W-1:0] unused_beat_mask;

   assign unused_beat_mask = BEAT_MASK;
   assign arburst    = 2'b01;
   assign wr_idx     = beat_cnt & IDX_MASK;
   assign crit_valid = 1'b0;
   assign crit_data  = '0;

   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && req_valid) araddr_q <= req_addr & LINE_MASK;
      if ((state == ST_R) && beat_fire)    line_buf[wr_idx] <= rdata;
   end
`endif

   // Line buffer is exposed directly; it only changes once a new request is in flight.
   always_comb begin
      resp_data = '0;
      for (int i = 0; i < BURST_LEN; i++) resp_data[i*DATA_W +: DATA_W] = line_buf[i];
   end

endmodule

// File: tb/tb_axi4_ifetch_line_master.sv
// Directed bench for axi4_ifetch_line_master (DATA_W=32, BURST_LEN=4); the bench plays the AXI slave.
module tb_axi4_ifetch_line_master;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [31:0]  req_addr;
   logic         cancel;
   logic         resp_valid;
   logic [127:0] resp_data;
   logic         resp_err;
   logic         crit_valid;
   logic [31:0]  crit_data;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arlock;
   logic [3:0]   arcache;
   logic [2:0]   arprot;
   logic [3:0]   arqos;
   logic [3:0]   arregion;
   logic         arvalid;
   logic         arready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;

   int errors = 0;
   int checks = 0;
   int rv_cnt = 0;
   int ar_cnt = 0;
   int rv0;
   int ar0;

   axi4_ifetch_line_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .cancel(cancel),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .crit_valid(crit_valid), .crit_data(crit_data),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (resp_valid)         rv_cnt <= rv_cnt + 1;
      if (arvalid && arready) ar_cnt <= ar_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int start_of(input logic [31:0] addr);
`ifdef AXI4_IFETCH_CRITICAL_WORD_EN
      return int'(addr[3:2]);
`else
      return 0;
`endif
   endfunction

   function automatic logic [31:0] exp_araddr(input logic [31:0] addr);
`ifdef AXI4_IFETCH_CRITICAL_WORD_EN
      return addr & 32'hFFFF_FFFC;
`else
      return addr & 32'hFFFF_FFF0;
`endif
   endfunction

   // Beat i of a burst carries base*(i+1); it lands in line word (start+i) mod 4.
   function automatic logic [127:0] exp_line(input logic [31:0] base, input int start);
      logic [127:0] l;
      l = '0;
      for (int i = 0; i < 4; i++) l[((start + i) % 4)*32 +: 32] = 32'(base * (i + 1));
      return l;
   endfunction

   task automatic do_req(input logic [31:0] addr);
      req_valid = 1'b1;
      req_addr  = addr;
      check("req_ready_idle", req_ready, 1);
      tick();
      req_valid = 1'b0;
      check("arvalid_after_req", arvalid, 1);
      check("req_ready_busy", req_ready, 0);
      check("araddr", araddr, exp_araddr(addr));
`ifdef AXI4_IFETCH_CRITICAL_WORD_EN
      check("arburst", arburst, 2'b10);
`else
      check("arburst", arburst, 2'b01);
`endif
   endtask

   task automatic ar_hs(input int stall, input logic [31:0] addr);
      arready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         tick();
         check("arvalid_stall", arvalid, 1);
         check("araddr_stall", araddr, exp_araddr(addr));
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
   endtask

   task automatic send_beats(input logic [31:0] base, input int err_idx, input bit cancel_last,
                             input bit exp_crit);
      int n;
      for (int i = 0; i < 4; i++) begin
         rvalid = 1'b1;
         rdata  = 32'(base * (i + 1));
         rresp  = (i == err_idx) ? 2'b10 : 2'b00;
         rlast  = (i == 3);
         cancel = cancel_last && (i == 3);
         n = 0;
         while (!rready && n < 20) begin
            tick();
            n++;
         end
         check("rready", rready, 1);
         tick();
         if (i == 0) begin
`ifdef AXI4_IFETCH_CRITICAL_WORD_EN
            check("crit_valid", crit_valid, exp_crit);
            if (exp_crit) check("crit_data", crit_data, base);
`else
            check("crit_valid", crit_valid, 0);
            check("crit_data", crit_data, 0);
`endif
         end
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      cancel = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; cancel = 1'b0;
      arready = 1'b0; rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      repeat (3) tick();
      check("rst_arvalid", arvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_crit_valid", crit_valid, 0);
      rst = 1'b0;
      tick();
      check("idle_req_ready", req_ready, 1);

      // Basic line fill with immediate arready
      do_req(32'h1C00_0014);
      check("arlen", arlen, 8'd3);
      check("arsize", arsize, 3'd2);
      check("arid", arid, 4'd0);
      ar_hs(0, 32'h1C00_0014);
      rv0 = rv_cnt;
      send_beats(32'h11, -1, 1'b0, 1'b1);
      check("t1_resp_valid", resp_valid, 1);
      check("t1_resp_err", resp_err, 0);
      check("t1_resp_data", resp_data, exp_line(32'h11, start_of(32'h1C00_0014)));
`ifndef AXI4_IFETCH_CRITICAL_WORD_EN
      check("t1_resp_data_hand", resp_data, 128'h00000044_00000033_00000022_00000011);
`endif
      tick();
      check("t1_resp_valid_pulse", resp_valid, 0);
      check("t1_pulse_count", rv_cnt - rv0, 1);
      check("t1_data_hold", resp_data, exp_line(32'h11, start_of(32'h1C00_0014)));

      // arready stalled five cycles
      do_req(32'h1C00_0040);
      ar0 = ar_cnt;
      ar_hs(5, 32'h1C00_0040);
      check("t2_ar_handshakes", ar_cnt - ar0, 1);
      send_beats(32'h1000, -1, 1'b0, 1'b1);
      check("t2_resp_valid", resp_valid, 1);
      check("t2_resp_data", resp_data, exp_line(32'h1000, 0));
      tick();

      // Cancel while in AR: burst is drained, no response
      do_req(32'h1C00_0100);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("t3_arvalid_held", arvalid, 1);
      rv0 = rv_cnt;
      ar_hs(0, 32'h1C00_0100);
      send_beats(32'h2000, -1, 1'b0, 1'b0);
      check("t3_resp_valid", resp_valid, 0);
      tick();
      check("t3_no_pulse", rv_cnt - rv0, 0);
      check("t3_req_ready", req_ready, 1);

      // Cancel coincident with the last beat, then a clean line
      do_req(32'h1C00_0080);
      ar_hs(0, 32'h1C00_0080);
      rv0 = rv_cnt;
      send_beats(32'h3000, -1, 1'b1, 1'b1);
      check("t4_resp_valid", resp_valid, 0);
      tick();
      check("t4_no_pulse", rv_cnt - rv0, 0);
      check("t4_req_ready", req_ready, 1);
      do_req(32'h1C00_0020);
      ar_hs(0, 32'h1C00_0020);
      send_beats(32'h4000, -1, 1'b0, 1'b1);
      check("t4b_resp_valid", resp_valid, 1);
      check("t4b_resp_data", resp_data, exp_line(32'h4000, 0));
      tick();

      // SLVERR on beat 2, then a clean line clears resp_err
      do_req(32'h1C00_0200);
      ar_hs(0, 32'h1C00_0200);
      send_beats(32'h5000, 2, 1'b0, 1'b1);
      check("t5_resp_valid", resp_valid, 1);
      check("t5_resp_err", resp_err, 1);
      tick();
      check("t5_resp_err_hold", resp_err, 1);
      do_req(32'h1C00_0240);
      check("t5_resp_err_cleared", resp_err, 0);
      ar_hs(0, 32'h1C00_0240);
      send_beats(32'h5100, -1, 1'b0, 1'b1);
      check("t5b_resp_valid", resp_valid, 1);
      check("t5b_resp_err", resp_err, 0);
      tick();

`ifdef AXI4_IFETCH_CRITICAL_WORD_EN
      // Critical word first: beat 0 goes to word 2
      do_req(32'h1C00_0018);
      ar_hs(0, 32'h1C00_0018);
      send_beats(32'h6000, -1, 1'b0, 1'b1);
      check("t6_resp_valid", resp_valid, 1);
      check("t6_word2", resp_data[95:64], 32'h6000);
      check("t6_resp_data", resp_data, exp_line(32'h6000, 2));
      tick();
`endif

      // Reset in the middle of a burst
      do_req(32'h1C00_0300);
      ar_hs(0, 32'h1C00_0300);
      check("t7_rready", rready, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t7_rready_after_rst", rready, 0);
      check("t7_arvalid_after_rst", arvalid, 0);
      check("t7_req_ready_after_rst", req_ready, 1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
